// File: rtl/alu_pkg.sv
// Shared opcode encodings and sequencer state type for the execute-stage
// ALU interface.
package alu_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_NOP  = 3'b000;
  localparam opcode_t OP_XOR  = 3'b001;
  localparam opcode_t OP_ADD  = 3'b010;
  localparam opcode_t OP_SUB  = 3'b011;
  localparam opcode_t OP_MUL  = 3'b100;
  localparam opcode_t OP_SHR  = 3'b101;
  localparam opcode_t OP_SHL  = 3'b110;
  localparam opcode_t OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/vec_alu_sequencer_lane_select.sv
// Combinational extraction of one lane from a packed vector.
module lane_select #(
  parameter int unsigned dataSize = 8,
  parameter int unsigned lanes    = 4
) (
  input  logic [lanes*dataSize-1:0]  vec,
  input  logic [$clog2(lanes)-1:0]   idx,
  output logic [dataSize-1:0]        lane
);

  localparam int unsigned CW = $clog2(lanes);

  always_comb begin
    lane = '0;
    for (int unsigned i = 0; i < lanes; i++) begin
      if (idx == CW'(i)) lane = vec[i*dataSize +: dataSize];
    end
  end

endmodule

// File: rtl/vec_alu_sequencer.sv
// Issues one vector operation lane by lane to an external single-lane ALU
// and assembles the vector result with per-lane zero/neg masks.
module vec_alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned dataSize = 8,
  parameter int unsigned lanes    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_opcode,
  input  logic [lanes*dataSize-1:0]  in_vec_a,
  input  logic [lanes*dataSize-1:0]  in_vec_b,
  input  logic                       in_scalar_b,
  output logic [2:0]                 alu_operation_select,
  output logic [dataSize-1:0]        alu_operand1,
  output logic [dataSize-1:0]        alu_operand2,
  input  logic [dataSize-1:0]        alu_result,
  input  logic                       alu_neg_flag,
  input  logic                       alu_zero_flag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [lanes*dataSize-1:0]  out_vec,
  output logic [lanes-1:0]           out_zero_mask,
  output logic [lanes-1:0]           out_neg_mask,
  output logic                       out_all_zero
);

  localparam int unsigned     CW        = $clog2(lanes);
  localparam logic [CW-1:0]   LAST_LANE = CW'(lanes - 1);

  state_t                    state;
  logic [CW-1:0]             lane_cnt;
  opcode_t                   op_q;
  logic [lanes*dataSize-1:0] vec_a_q;
  logic [lanes*dataSize-1:0] vec_b_q;
  logic                      scalar_q;
  logic [CW-1:0]             b_idx;
  logic [dataSize-1:0]       a_lane;
  logic [dataSize-1:0]       b_lane;

  assign b_idx = scalar_q ? '0 : lane_cnt;

  lane_select #(.dataSize(dataSize), .lanes(lanes)) u_sel_a (
    .vec  (vec_a_q),
    .idx  (lane_cnt),
    .lane (a_lane)
  );

  lane_select #(.dataSize(dataSize), .lanes(lanes)) u_sel_b (
    .vec  (vec_b_q),
    .idx  (b_idx),
    .lane (b_lane)
  );

  // ALU drive is gated by state so it reads as idle whenever not issuing.
  always_comb begin
    alu_operation_select = '0;
    alu_operand1         = '0;
    alu_operand2         = '0;
    if (state == RUN) begin
      alu_operation_select = op_q;
      alu_operand1         = a_lane;
      alu_operand2         = b_lane;
    end
  end

  assign out_all_zero = &out_zero_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      lane_cnt      <= '0;
      op_q          <= '0;
      vec_a_q       <= '0;
      vec_b_q       <= '0;
      scalar_q      <= 1'b0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_vec       <= '0;
      out_zero_mask <= '0;
      out_neg_mask  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_q     <= in_opcode;
            vec_a_q  <= in_vec_a;
            vec_b_q  <= in_vec_b;
            scalar_q <= in_scalar_b;
            lane_cnt <= '0;
            in_ready <= 1'b0;
            if (in_opcode == OP_NOP) begin
              out_vec       <= '0;
              out_zero_mask <= '1;
              out_neg_mask  <= '0;
              out_valid     <= 1'b1;
              state         <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < lanes; i++) begin
            if (lane_cnt == CW'(i)) out_vec[i*dataSize +: dataSize] <= alu_result;
          end
          out_zero_mask[lane_cnt] <= alu_zero_flag;
          out_neg_mask[lane_cnt]  <= alu_neg_flag;
          if (lane_cnt == LAST_LANE) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            lane_cnt <= lane_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Scoreboard bench for vec_alu_sequencer with a behavioural single-lane ALU.
module tb_vec_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_opcode;
  logic [31:0] in_vec_a;
  logic [31:0] in_vec_b;
  logic        in_scalar_b;
  logic [2:0]  alu_operation_select;
  logic [7:0]  alu_operand1;
  logic [7:0]  alu_operand2;
  logic [7:0]  alu_result;
  logic        alu_neg_flag;
  logic        alu_zero_flag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_vec;
  logic [3:0]  out_zero_mask;
  logic [3:0]  out_neg_mask;
  logic        out_all_zero;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] vec;
    logic [3:0]  z;
    logic [3:0]  n;
    logic        az;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  vec_alu_sequencer #(.dataSize(8), .lanes(4)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_opcode            (in_opcode),
    .in_vec_a             (in_vec_a),
    .in_vec_b             (in_vec_b),
    .in_scalar_b          (in_scalar_b),
    .alu_operation_select (alu_operation_select),
    .alu_operand1         (alu_operand1),
    .alu_operand2         (alu_operand2),
    .alu_result           (alu_result),
    .alu_neg_flag         (alu_neg_flag),
    .alu_zero_flag        (alu_zero_flag),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_vec              (out_vec),
    .out_zero_mask        (out_zero_mask),
    .out_neg_mask         (out_neg_mask),
    .out_all_zero         (out_all_zero)
  );

  // Returns {neg, result}; neg is reported only for ADD/SUB.
  function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    case (op)
      3'b001:  r = x ^ y;
      3'b010:  r = x + y;
      3'b011:  r = x - y;
      3'b100:  r = x * y;
      3'b101:  r = x >> y;
      3'b110:  r = x << y;
      default: r = 8'h00;
    endcase
    return {((op == 3'b010) || (op == 3'b011)) && r[7], r};
  endfunction

  always_comb begin
    {alu_neg_flag, alu_result} = alu_fn(alu_operation_select, alu_operand1, alu_operand2);
    alu_zero_flag = (alu_result == 8'h00);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic sb);
    @(negedge clk);
    check("accept_ready", in_ready, 1);
    in_valid    = 1'b1;
    in_opcode   = op;
    in_vec_a    = a;
    in_vec_b    = b;
    in_scalar_b = sb;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_opcode   = 3'($urandom);
    in_vec_a    = $urandom;
    in_vec_b    = $urandom;
    in_scalar_b = 1'($urandom);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic sb, input int exp_lat);
    exp_t e;
    exp_t got_e;
    logic [7:0] r;
    logic [8:0] nr;
    int c;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      nr = alu_fn(op, a[i*8 +: 8], sb ? b[7:0] : b[i*8 +: 8]);
      r  = nr[7:0];
      e.vec[i*8 +: 8] = r;
      e.z[i] = (r == 8'h00);
      e.n[i] = nr[8];
    end
    e.az = &e.z;
    sb_q.push_back(e);
    do_accept(op, a, b, sb);
    c = 0;
    while (c < 20) begin
      @(negedge clk);
      c++;
      if (out_valid) break;
      if (c <= 4) begin
        check("opsel", alu_operation_select, op);
        check("operand1", alu_operand1, a[(c-1)*8 +: 8]);
        check("operand2", alu_operand2, sb ? b[7:0] : b[(c-1)*8 +: 8]);
      end
    end
    check("latency", c, exp_lat);
    if (out_valid && sb_q.size() > 0) begin
      got_e = sb_q.pop_front();
      check("out_vec", out_vec, got_e.vec);
      check("zero_mask", out_zero_mask, got_e.z);
      check("neg_mask", out_neg_mask, got_e.n);
      check("all_zero", out_all_zero, got_e.az);
      check("done_ready", in_ready, 0);
    end else begin
      check("timeout_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_ready", in_ready, 1);
    check("post_valid", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [31:0] hold_vec;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_opcode   = '0;
    in_vec_a    = '0;
    in_vec_b    = '0;
    in_scalar_b = 1'b0;
    out_ready   = 1'b0;

    // 1: reset
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_vec", out_vec, 0);
    check("rst_opsel", alu_operation_select, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready", in_ready, 1);
    check("rel_valid", out_valid, 0);
    check("rel_vec", out_vec, 0);
    check("rel_zmask", out_zero_mask, 0);
    check("rel_nmask", out_neg_mask, 0);
    check("rel_allzero", out_all_zero, 0);
    check("rel_opsel", alu_operation_select, 0);
    check("rel_op1", alu_operand1, 0);
    check("rel_op2", alu_operand2, 0);

    // 2-4: arithmetic, all-zero, scalar broadcast
    run_op(3'b010, 32'h7F030201, 32'h01010101, 1'b0, 5);
    run_op(3'b011, 32'h050900C8, 32'h050900C8, 1'b0, 5);
    run_op(3'b110, 32'h01020304, 32'h07070702, 1'b1, 5);
    run_op(3'b100, 32'h10FF0703, 32'h10020509, 1'b0, 5);
    run_op(3'b101, 32'h80F0FF40, 32'h07040102, 1'b0, 5);
    run_op(3'b111, 32'h12345678, 32'h9ABCDEF0, 1'b0, 5);

    // 5: NOP, then backpressure with an ignored in_valid pulse
    e = '{vec: 32'h0, z: 4'hF, n: 4'h0, az: 1'b1};
    sb_q.push_back(e);
    do_accept(3'b000, 32'hAAAAAAAA, 32'h55555555, 1'b0);
    @(negedge clk);
    check("nop_valid", out_valid, 1);
    check("nop_opsel", alu_operation_select, 0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("nop_vec", out_vec, e.vec);
      check("nop_zmask", out_zero_mask, e.z);
      check("nop_nmask", out_neg_mask, e.n);
      check("nop_allzero", out_all_zero, e.az);
    end
    hold_vec = out_vec;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        in_valid  = 1'b1;
        in_opcode = 3'b010;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_ready", in_ready, 0);
      check("bp_vec", out_vec, hold_vec);
      check("bp_zmask", out_zero_mask, 4'hF);
      check("bp_opsel", alu_operation_select, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("nop_idle_ready", in_ready, 1);
    check("nop_idle_valid", out_valid, 0);
    check("nop_idle_opsel", alu_operation_select, 0);

    // 6: reset in the middle of a MUL
    do_accept(3'b100, 32'h09070503, 32'h02020202, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("mul_k2_op1", alu_operand1, 8'h07);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_opsel", alu_operation_select, 0);
    check("mid_rst_op1", alu_operand1, 0);
    check("mid_rst_vec", out_vec, 0);
    check("mid_rst_zmask", out_zero_mask, 0);
    check("mid_rst_nmask", out_neg_mask, 0);
    check("mid_rst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rel_ready", in_ready, 1);
    run_op(3'b001, 32'hFFFFFFFF, 32'h0F0F0F0F, 1'b0, 5);
    check("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
